// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: walks an spram address window, latching one pattern word per step onto led.
// Optional build macro LED_SEQ_ONESHOT_EN plays a single lap and then parks in DONE.
module led_pattern_sequencer #(
  parameter int addrbits  = 9,
  parameter int databits  = 8,
  parameter int dwellbits = 24
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [addrbits-1:0]  start_addr,
  input  logic [addrbits-1:0]  end_addr,
  input  logic [dwellbits-1:0] dwell,
  output logic [addrbits-1:0]  mem_address,
  output logic                 mem_wren,
  input  logic [databits-1:0]  mem_q,
  output logic [databits-1:0]  led,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]           state;
  logic [addrbits-1:0]  addr;
  logic [addrbits-1:0]  start_r;
  logic [addrbits-1:0]  end_r;
  logic [dwellbits-1:0] dwell_r;
  logic [dwellbits-1:0] count;
  logic                 step_end;
  logic                 at_end;

  // A zero dwell still holds the pattern for one cycle.
  function automatic logic [dwellbits-1:0] dwell_load(input logic [dwellbits-1:0] d);
    return (d == '0) ? '0 : d - dwellbits'(1);
  endfunction

  function automatic logic [addrbits-1:0] next_addr(input logic [addrbits-1:0] a);
    return a + addrbits'(1);
  endfunction

  assign step_end    = (state == HOLD) && (count == '0);
  assign at_end      = (addr == end_r);
  assign mem_address = addr;
  assign mem_wren    = (state != READ);
  assign busy        = (state != IDLE) && (state != DONE);

`ifdef LED_SEQ_ONESHOT_EN
  assign wrap = 1'b0;
  assign done = (state == DONE);
`else
  assign wrap = step_end && at_end;
  assign done = 1'b0;
`endif

  // Window bounds and dwell are captured on leaving IDLE and are not reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      count <= '0;
      led   <= '0;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          start_r <= start_addr;
          end_r   <= end_addr;
          dwell_r <= dwell;
          addr    <= start_addr;
          state   <= READ;
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          led   <= mem_q;
          count <= dwell_load(dwell_r);
          state <= HOLD;
        end
        HOLD: begin
          if (!step_end) begin
            count <= count - dwellbits'(1);
          end else if (at_end) begin
`ifdef LED_SEQ_ONESHOT_EN
            state <= DONE;
`else
            addr  <= start_r;
            state <= READ;
`endif
          end else begin
            addr  <= next_addr(addr);
            state <= READ;
          end
        end
`ifdef LED_SEQ_ONESHOT_EN
        DONE: begin
          state <= DONE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected reads are queued from a step/lap model
// of the pattern walk, and a monitor checks every memory read, led update and wrap pulse.
module tb_led_pattern_sequencer;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int WW    = 24;
  localparam int AMASK = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [WW-1:0] dwell = '0;
  logic [AW-1:0] mem_address;
  logic          mem_wren;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] led;
  logic          busy;
  logic          wrap;
  logic          done;

  logic [DW-1:0] mem [0:AMASK];

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int            rc;
    int            addr;
    logic [DW-1:0] data;
    bit            wrap;
    bit            chk_led;
    int            per;
  } exp_t;

  exp_t sbq[$];
  int            pend_cyc = -1;
  logic [DW-1:0] pend_val = '0;
  int            wrap_cyc = -1;

  led_pattern_sequencer #(.addrbits(AW), .databits(DW), .dwellbits(WW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .start_addr(start_addr), .end_addr(end_addr), .dwell(dwell),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_q(mem_q),
    .led(led), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Single-port memory: registered read when wren is low, output holds otherwise.
  always @(posedge clock) if (!mem_wren) mem_q <= mem[mem_address];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clock); #1; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!mem_wren) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_read at cycle %0d: address 0x%0h, no read scheduled", cyc, mem_address);
        end else begin
          e = sbq.pop_front();
          chk("read_cycle", cyc, e.rc);
          chk("read_addr", mem_address, e.addr);
          if (e.chk_led) begin
            pend_cyc = cyc + 2;
            pend_val = e.data;
          end
          if (e.wrap) wrap_cyc = cyc + e.per - 1;
        end
      end
      if (cyc == pend_cyc) chk("led", led, pend_val);
      chk("wrap", wrap, (cyc == wrap_cyc) ? 1 : 0);
`ifndef LED_SEQ_ONESHOT_EN
      chk("done_tied", done, 0);
`endif
    end
  end

  // mode 0: run n steps then stop during the next read; 1: stop mid-HOLD of step n; 2: one full lap to DONE
  task automatic run(input int s, input int e, input int d, input int n, input int mode, input bit from_reset);
    int L, P, c, last_r, t;
    logic [DW-1:0] lastdata;
    exp_t x;
    L = ((e - s) & AMASK) + 1;
    P = ((d < 1) ? 1 : d) + 2;
`ifdef LED_SEQ_ONESHOT_EN
    if (mode == 0) mode = 2;
`endif
    if (mode == 2) n = L;
    start_addr = AW'(s);
    end_addr   = AW'(e);
    dwell      = WW'(d);
    if (!from_reset) begin
      tick(2);
      chk("idle_busy", busy, 0);
      chk("idle_wren", mem_wren, 1);
    end
    c = cyc;
    for (int k = 0; k < n + ((mode == 0) ? 1 : 0); k++) begin
      x.rc      = c + 1 + k * P;
      x.addr    = (s + (k % L)) & AMASK;
      x.data    = mem[x.addr];
      x.wrap    = ((k % L) == L - 1) && (((mode == 0) && (k < n)) || ((mode == 1) && (k < n - 1)));
      x.chk_led = (k < n);
      x.per     = P;
      sbq.push_back(x);
    end
    lastdata = mem[(s + ((n - 1) % L)) & AMASK];
    if (from_reset) reset_n = 1'b1;
    else enable = 1'b1;
    tick(1);
    start_addr = AW'($urandom);
    end_addr   = AW'($urandom);
    dwell      = WW'($urandom_range(0, 50));
    @(negedge clock);
    chk("busy_read", busy, 1);
    last_r = c + 1 + (n - 1) * P;
    if (mode == 0) begin
      t = last_r + P;
      wait_cyc(t);
      enable = 1'b0;
      tick(1);
      @(negedge clock);
      chk("stop_busy", busy, 0);
      chk("stop_wren", mem_wren, 1);
      chk("stop_led_held", led, lastdata);
    end else if (mode == 1) begin
      t = last_r + 3;
      wait_cyc(t);
      enable = 1'b0;
      tick(1);
      @(negedge clock);
      chk("abort_busy", busy, 0);
      chk("abort_wren", mem_wren, 1);
      chk("abort_led_held", led, lastdata);
    end
`ifdef LED_SEQ_ONESHOT_EN
    else begin
      t = last_r + P;
      wait_cyc(t);
      @(negedge clock);
      chk("done_set", done, 1);
      chk("done_busy", busy, 0);
      chk("done_led", led, mem[e & AMASK]);
      chk("done_wren", mem_wren, 1);
      tick(2);
      chk("done_stays", done, 1);
      enable = 1'b0;
      tick(1);
      chk("done_clear", done, 0);
    end
`endif
    tick(2);
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d reads still queued", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int s, e, d, n, m;
    for (int i = 0; i <= AMASK; i++) mem[i] = DW'($urandom);

    // Reset held with enable high: everything stays at reset values.
    reset_n = 1'b0;
    enable  = 1'b1;
    start_addr = AW'(7);
    end_addr   = AW'(9);
    dwell      = WW'(2);
    tick(3);
    chk("rst_led", led, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wren", mem_wren, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    run(7, 9, 2, 5, 0, 1'b1);

    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    run(0, 3, 4, 9, 0, 1'b0);
    run(510, 1, 1, 9, 0, 1'b0);
    run(5, 5, 0, 4, 0, 1'b0);
    run(10, 20, 6, 3, 1, 1'b0);
    run(10, 20, 10, 3, 0, 1'b0);
`ifdef LED_SEQ_ONESHOT_EN
    run(0, 2, 2, 3, 2, 1'b0);
`endif

    for (int r = 0; r < 10; r++) begin
      s = $urandom_range(0, AMASK);
      e = (s + $urandom_range(0, 4)) & AMASK;
      m = $urandom_range(0, 1);
      d = (m == 1) ? $urandom_range(3, 6) : $urandom_range(0, 5);
      n = $urandom_range(1, 8);
      if (m == 1 && n > ((e - s) & AMASK) + 1) n = ((e - s) & AMASK) + 1;
      run(s, e, d, n, m, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
